// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the transmit-arbiter state encoding.
package eth_pkg;

  localparam int          MAC_W          = 48;
  localparam int          ETHERTYPE_W    = 16;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant of the first requester at or
// after i_ptr, wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic             o_valid
);

  logic [2*N-1:0] w_one;
  logic [2*N-1:0] w_double;
  logic [2*N-1:0] w_mask;
  logic [2*N-1:0] w_masked;
  logic [2*N-1:0] w_lowest;

  // The upper copy of the request vector is never masked, so when nothing at
  // or above the pointer is requesting, the lowest surviving bit is the wrap.
  always_comb begin
    w_one    = {{(2*N-1){1'b0}}, 1'b1};
    w_double = {i_req, i_req};
    w_mask   = ~((w_one << i_ptr) - w_one);
    w_masked = w_double & w_mask;
    w_lowest = w_masked & (~w_masked + w_one);
    o_gnt    = w_lowest[N-1:0] | w_lowest[2*N-1:N];
    o_valid  = |i_req;
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-level round-robin arbiter feeding one eth_framer from N frame sources;
// a grant is held for a whole packet and the owner's sideband is latched at grant.
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int N_INPUTS   = 2,
  parameter int AXIS_BYTES = 4
) (
  input  logic                               clk,
  input  logic                               sreset,
  input  logic [N_INPUTS-1:0]                axis_i_tvalid,
  output logic [N_INPUTS-1:0]                axis_i_tready,
  input  logic [N_INPUTS-1:0]                axis_i_tlast,
  input  logic [N_INPUTS*AXIS_BYTES-1:0]     axis_i_tkeep,
  input  logic [N_INPUTS*AXIS_BYTES*8-1:0]   axis_i_tdata,
  input  logic [N_INPUTS*48-1:0]             axis_i_dst_mac,
  input  logic [N_INPUTS*16-1:0]             axis_i_ethertype,
  output logic                               axis_o_tvalid,
  input  logic                               axis_o_tready,
  output logic                               axis_o_tlast,
  output logic [AXIS_BYTES-1:0]              axis_o_tkeep,
  output logic [AXIS_BYTES*8-1:0]            axis_o_tdata,
  output logic [47:0]                        axis_o_dst_mac,
  output logic [15:0]                        axis_o_ethertype,
  output logic [N_INPUTS-1:0]                grant_o
);

  localparam int PTR_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int DATA_W = AXIS_BYTES * 8;

  arb_state_e              r_state;
  arb_state_e              w_state_nxt;
  logic [N_INPUTS-1:0]     r_grant;
  logic [N_INPUTS-1:0]     w_grant_nxt;
  logic [N_INPUTS-1:0]     w_arb_gnt;
  logic                    w_arb_valid;
  logic [PTR_W-1:0]        r_ptr;
  logic [PTR_W-1:0]        w_ptr_nxt;
  logic [PTR_W-1:0]        w_cur_idx;
  logic [MAC_W-1:0]        r_dst_mac;
  logic [MAC_W-1:0]        w_dst_mac_nxt;
  logic [MAC_W-1:0]        w_pick_mac;
  logic [ETHERTYPE_W-1:0]  r_ethertype;
  logic [ETHERTYPE_W-1:0]  w_ethertype_nxt;
  logic [ETHERTYPE_W-1:0]  w_pick_et;
  logic                    w_busy;
  logic                    w_beat_last;

  rr_arbiter #(
    .N     (N_INPUTS),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .i_req   (axis_i_tvalid),
    .i_ptr   (r_ptr),
    .o_gnt   (w_arb_gnt),
    .o_valid (w_arb_valid)
  );

  // AND-OR selects: sideband of the source being picked, index of the current owner.
  always_comb begin
    w_pick_mac = {MAC_W{1'b0}};
    w_pick_et  = {ETHERTYPE_W{1'b0}};
    w_cur_idx  = {PTR_W{1'b0}};
    for (int k = 0; k < N_INPUTS; k++) begin
      w_pick_mac = w_pick_mac | (axis_i_dst_mac[k*MAC_W +: MAC_W] & {MAC_W{w_arb_gnt[k]}});
      w_pick_et  = w_pick_et  | (axis_i_ethertype[k*ETHERTYPE_W +: ETHERTYPE_W] & {ETHERTYPE_W{w_arb_gnt[k]}});
      w_cur_idx  = w_cur_idx  | (PTR_W'(k) & {PTR_W{r_grant[k]}});
    end
  end

  // Pass-through of the granted source; nothing moves while idle.
  always_comb begin
    w_busy        = (r_state == ST_BUSY);
    axis_o_tvalid = 1'b0;
    axis_o_tlast  = 1'b0;
    axis_o_tkeep  = {AXIS_BYTES{1'b0}};
    axis_o_tdata  = {DATA_W{1'b0}};
    for (int k = 0; k < N_INPUTS; k++) begin
      axis_o_tvalid = axis_o_tvalid | (axis_i_tvalid[k] & r_grant[k] & w_busy);
      axis_o_tlast  = axis_o_tlast  | (axis_i_tlast[k]  & r_grant[k] & w_busy);
      axis_o_tkeep  = axis_o_tkeep  | (axis_i_tkeep[k*AXIS_BYTES +: AXIS_BYTES] & {AXIS_BYTES{r_grant[k] & w_busy}});
      axis_o_tdata  = axis_o_tdata  | (axis_i_tdata[k*DATA_W +: DATA_W] & {DATA_W{r_grant[k] & w_busy}});
    end
    axis_i_tready    = r_grant & {N_INPUTS{axis_o_tready & w_busy}};
    axis_o_dst_mac   = r_dst_mac;
    axis_o_ethertype = r_ethertype;
    grant_o          = r_grant;
  end

  // Next-state logic: grant on any request in IDLE, release on the tlast handshake.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_ptr_nxt       = r_ptr;
    w_dst_mac_nxt   = r_dst_mac;
    w_ethertype_nxt = r_ethertype;
    w_beat_last     = axis_o_tvalid & axis_o_tready & axis_o_tlast;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          w_state_nxt     = ST_BUSY;
          w_grant_nxt     = w_arb_gnt;
          w_dst_mac_nxt   = w_pick_mac;
          w_ethertype_nxt = w_pick_et;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_beat_last) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = {N_INPUTS{1'b0}};
          // Wrap at N_INPUTS, not at the power of two the pointer can hold.
          w_ptr_nxt   = (w_cur_idx == PTR_W'(N_INPUTS - 1)) ? {PTR_W{1'b0}}
                                                             : w_cur_idx + PTR_W'(1);
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = {N_INPUTS{1'b0}};
      end
    endcase
  end

  // State, grant, pointer and latched sideband registers.
  always_ff @(posedge clk) begin
    if (sreset) begin
      r_state     <= ST_IDLE;
      r_grant     <= {N_INPUTS{1'b0}};
      r_ptr       <= {PTR_W{1'b0}};
      r_dst_mac   <= {MAC_W{1'b0}};
      r_ethertype <= {ETHERTYPE_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_ptr       <= w_ptr_nxt;
      r_dst_mac   <= w_dst_mac_nxt;
      r_ethertype <= w_ethertype_nxt;
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Randomised bench for eth_tx_arbiter: per-source beat queues act as both
// stimulus and scoreboard, and a packet-level round-robin model predicts grants.
module tb_eth_tx_arbiter;
  import eth_pkg::*;

  localparam int N  = 3;
  localparam int B  = 4;
  localparam int DW = B * 8;

  logic              clk = 1'b0;
  logic              sreset = 1'b1;
  logic [N-1:0]      axis_i_tvalid = '0;
  logic [N-1:0]      axis_i_tready;
  logic [N-1:0]      axis_i_tlast = '0;
  logic [N*B-1:0]    axis_i_tkeep = '0;
  logic [N*DW-1:0]   axis_i_tdata = '0;
  logic [N*48-1:0]   axis_i_dst_mac = '0;
  logic [N*16-1:0]   axis_i_ethertype = '0;
  logic              axis_o_tvalid;
  logic              axis_o_tready = 1'b0;
  logic              axis_o_tlast;
  logic [B-1:0]      axis_o_tkeep;
  logic [DW-1:0]     axis_o_tdata;
  logic [47:0]       axis_o_dst_mac;
  logic [15:0]       axis_o_ethertype;
  logic [N-1:0]      grant_o;

  eth_tx_arbiter #(.N_INPUTS(N), .AXIS_BYTES(B)) dut (
    .clk(clk), .sreset(sreset),
    .axis_i_tvalid(axis_i_tvalid), .axis_i_tready(axis_i_tready),
    .axis_i_tlast(axis_i_tlast), .axis_i_tkeep(axis_i_tkeep),
    .axis_i_tdata(axis_i_tdata), .axis_i_dst_mac(axis_i_dst_mac),
    .axis_i_ethertype(axis_i_ethertype),
    .axis_o_tvalid(axis_o_tvalid), .axis_o_tready(axis_o_tready),
    .axis_o_tlast(axis_o_tlast), .axis_o_tkeep(axis_o_tkeep),
    .axis_o_tdata(axis_o_tdata), .axis_o_dst_mac(axis_o_dst_mac),
    .axis_o_ethertype(axis_o_ethertype), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [B-1:0]  keep;
    logic          last;
    logic [47:0]   mac;
    logic [15:0]   et;
  } beat_t;

  beat_t       src_q [N][$];
  int          vprob [N];
  int          hold [N];
  int          rprob;
  bit          mac_ovr_en [N];
  logic [47:0] mac_ovr [N];
  bit          m_busy;
  int          m_owner;
  int          m_ptr;
  logic [47:0] m_mac;
  logic [15:0] m_et;
  int          pkt_cnt [N];
  int          xfer_cnt [N];
  int          loaded [N];
  int          order_q [$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic add_pkt(input int k, input int len, input logic [47:0] mac, input logic [15:0] et);
    beat_t b;
    int    nb;
    for (int i = 0; i < len; i++) begin
      b.data = $urandom;
      b.last = (i == len - 1);
      b.keep = '1;
      if (b.last) begin
        nb     = $urandom_range(1, B);
        b.keep = '0;
        for (int j = 0; j < nb; j++) b.keep[j] = 1'b1;
      end
      b.mac = mac;
      b.et  = et;
      src_q[k].push_back(b);
    end
    loaded[k]++;
  endtask

  task automatic reset_model();
    for (int k = 0; k < N; k++) begin
      src_q[k].delete();
      vprob[k] = 100; hold[k] = 0; mac_ovr_en[k] = 1'b0; mac_ovr[k] = '0;
      pkt_cnt[k] = 0; xfer_cnt[k] = 0; loaded[k] = 0;
    end
    order_q.delete();
    rprob = 100; m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_mac = '0; m_et = '0;
  endtask

  task automatic do_reset(input bit valids_on, input int cycles);
    @(negedge clk);
    sreset = 1'b1;
    axis_i_tvalid = valids_on ? '1 : '0;
    axis_i_tdata = '0; axis_i_tkeep = '0; axis_i_tlast = '0;
    axis_o_tready = 1'b1;
    repeat (cycles) @(negedge clk);
    #1;
    check("rst_tready", axis_i_tready, 0);
    check("rst_tvalid", axis_o_tvalid, 0);
    check("rst_grant", grant_o, 0);
    check("rst_mac", axis_o_dst_mac, 0);
    check("rst_etype", axis_o_ethertype, 0);
    sreset = 1'b0;
    axis_i_tvalid = '0;
    reset_model();
  endtask

  // One clock: drive sources, check outputs mid-cycle, then advance the model.
  task automatic step();
    logic [N-1:0] v;
    logic [N-1:0] exp_tr;
    logic [N-1:0] exp_g;
    logic [47:0]  drv_mac [N];
    logic [15:0]  drv_et [N];
    beat_t        b;
    int           c;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      v[k] = 1'b0; drv_mac[k] = '0; drv_et[k] = '0;
      axis_i_tdata[k*DW +: DW] = '0; axis_i_tkeep[k*B +: B] = '0; axis_i_tlast[k] = 1'b0;
      if (src_q[k].size() > 0) begin
        drv_mac[k] = mac_ovr_en[k] ? mac_ovr[k] : src_q[k][0].mac;
        drv_et[k]  = src_q[k][0].et;
        axis_i_tdata[k*DW +: DW] = src_q[k][0].data;
        axis_i_tkeep[k*B +: B]   = src_q[k][0].keep;
        axis_i_tlast[k]          = src_q[k][0].last;
        if (hold[k] > 0) hold[k]--;
        else v[k] = ($urandom_range(0, 99) < vprob[k]);
      end
      axis_i_dst_mac[k*48 +: 48]   = drv_mac[k];
      axis_i_ethertype[k*16 +: 16] = drv_et[k];
    end
    axis_i_tvalid = v;
    axis_o_tready = ($urandom_range(0, 99) < rprob);
    #1;
    exp_tr = '0; exp_g = '0;
    if (m_busy) begin
      exp_tr[m_owner] = axis_o_tready;
      exp_g[m_owner]  = 1'b1;
    end
    check("grant", grant_o, exp_g);
    check("tready", axis_i_tready, exp_tr);
    check("tvalid", axis_o_tvalid, m_busy && v[m_owner]);
    if (m_busy) begin
      check("mac", axis_o_dst_mac, m_mac);
      check("etype", axis_o_ethertype, m_et);
      if (v[m_owner]) begin
        check("data", axis_o_tdata, src_q[m_owner][0].data);
        check("keep", axis_o_tkeep, src_q[m_owner][0].keep);
        check("last", axis_o_tlast, src_q[m_owner][0].last);
      end
    end
    if (!m_busy) begin
      for (int i = 0; i < N; i++) begin
        c = (m_ptr + i) % N;
        if (v[c] && !m_busy) begin
          m_busy = 1'b1; m_owner = c;
          m_mac = drv_mac[c]; m_et = drv_et[c];
          order_q.push_back(c);
        end
      end
    end else if (v[m_owner] && axis_o_tready) begin
      b = src_q[m_owner].pop_front();
      xfer_cnt[m_owner]++;
      if (b.last) begin
        m_busy = 1'b0;
        m_ptr = (m_owner + 1) % N;
        pkt_cnt[m_owner]++;
      end
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < N; k++) s += src_q[k].size();
    return s;
  endfunction

  task automatic run_until_empty(input string tag, input int budget, output int steps);
    steps = 0;
    while ((pending() > 0 || m_busy) && steps < budget) begin
      step();
      steps++;
    end
    check(tag, pending(), 0);
  endtask

  int steps;
  int total;
  int mx;
  int mn;

  initial begin
    reset_model();
    // reset with every source requesting
    do_reset(1'b1, 3);

    // lone ARP packet from source 0
    do_reset(1'b0, 2);
    add_pkt(0, 7, 48'hffffffffffff, ETHERTYPE_ARP);
    run_until_empty("t2_drain", 50, steps);
    check("t2_beats", xfer_cnt[0], 7);
    check("t2_cycles", steps, 8);
    step();
    check("t2_idle_grant", grant_o, 0);

    // two saturating sources alternate with a single bubble
    do_reset(1'b0, 2);
    for (int p = 0; p < 2; p++) begin
      add_pkt(0, 3, {16'($urandom), 32'($urandom)}, ETHERTYPE_IPV4);
      add_pkt(1, 3, {16'($urandom), 32'($urandom)}, ETHERTYPE_IPV4);
    end
    run_until_empty("t3_drain", 100, steps);
    check("t3_cycles", steps, 16);
    check("t3_npkts", order_q.size(), 4);
    for (int i = 0; i < order_q.size(); i++) check("t3_order", order_q[i], i % 2);
    check("t3_fair", pkt_cnt[0], pkt_cnt[1]);

    // granted source 1 stalls mid-packet while source 0 waits
    do_reset(1'b0, 2);
    add_pkt(1, 4, 48'h112233445566, ETHERTYPE_IPV4);
    step();
    add_pkt(0, 3, 48'h665544332211, ETHERTYPE_ARP);
    steps = 0;
    while (xfer_cnt[1] < 2 && steps < 20) begin step(); steps++; end
    check("t4_first_beats", xfer_cnt[1], 2);
    hold[1] = 5;
    run_until_empty("t4_drain", 100, steps);
    check("t4_npkts", order_q.size(), 2);
    check("t4_order0", order_q[0], 1);
    check("t4_order1", order_q[1], 0);

    // sideband changes after the first beat are ignored
    do_reset(1'b0, 2);
    add_pkt(0, 4, 48'h070605040302, ETHERTYPE_IPV4);
    steps = 0;
    while (xfer_cnt[0] < 1 && steps < 20) begin step(); steps++; end
    mac_ovr_en[0] = 1'b1;
    mac_ovr[0] = 48'h0a0b0c0d0e0f;
    step();
    check("t5_mac_hold", axis_o_dst_mac, 48'h070605040302);
    run_until_empty("t5_drain", 50, steps);

    // 1000 random packets over 3 sources with random backpressure
    do_reset(1'b0, 2);
    for (int i = 0; i < 1000; i++)
      add_pkt(i % N, $urandom_range(1, 8), {16'($urandom), 32'($urandom)},
              ($urandom_range(0, 1) == 1) ? ETHERTYPE_ARP : ETHERTYPE_IPV4);
    rprob = 70;
    total = 0; steps = 0;
    while (total < 30 && steps < 2000) begin
      step(); steps++;
      total = 0;
      for (int k = 0; k < N; k++) total += pkt_cnt[k];
    end
    mx = pkt_cnt[0]; mn = pkt_cnt[0];
    for (int k = 1; k < N; k++) begin
      if (pkt_cnt[k] > mx) mx = pkt_cnt[k];
      if (pkt_cnt[k] < mn) mn = pkt_cnt[k];
    end
    check("t6_fair_total", total, 30);
    check("t6_fair_spread", (mx - mn) <= 1, 1);
    for (int k = 0; k < N; k++) vprob[k] = $urandom_range(40, 95);
    rprob = 75;
    run_until_empty("t6_drain", 80000, steps);
    for (int k = 0; k < N; k++) check("t6_pkts", pkt_cnt[k], loaded[k]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
